// File: rtl/tb_irq_inject_sched_pkg.sv
// Shared definitions for the IRQ / ITCM-error stimulus scheduler: state
// encodings, default harness PCs and the LFSR step used to randomise gaps.
package tb_irq_pkg;

  typedef logic [1:0] src_state_t;
  typedef logic [1:0] err_state_t;

  localparam src_state_t SRC_IDLE   = 2'd0;
  localparam src_state_t SRC_WAIT   = 2'd1;
  localparam src_state_t SRC_ASSERT = 2'd2;
  localparam src_state_t SRC_DONE   = 2'd3;

  localparam err_state_t ERR_IDLE = 2'd0;
  localparam err_state_t ERR_LO   = 2'd1;
  localparam err_state_t ERR_HI   = 2'd2;
  localparam err_state_t ERR_DONE = 2'd3;

  localparam int          PC_W_DEF       = 32;
  localparam logic [31:0] PC_ARM_DEF     = 32'h8000_015C;
  localparam logic [31:0] PC_TOHOST_DEF  = 32'h8000_0086;
  localparam logic [31:0] PC_EXT_RET_DEF = 32'h8000_00A6;
  localparam logic [31:0] PC_SFT_RET_DEF = 32'h8000_00BE;
  localparam logic [31:0] PC_TMR_RET_DEF = 32'h8000_00D6;

  // x^16 + x^14 + x^13 + x^11 + 1 -> feedback from bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Fibonacci step: shift left, XOR of tapped bits enters at bit 0
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/tb_irq_inject_sched_if.sv
// Commit-monitor inputs and forced irq/err outputs of the stimulus scheduler.
// master = harness side driving commit info, slave = the scheduler.
interface tb_irq_inject_sched_if
  import tb_irq_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
);
  logic            cmt_vld;
  logic [PC_W-1:0] cmt_pc;
  logic            status_mie;
  logic            itcm_rsp_read;
  logic            ext_irq;
  logic            sft_irq;
  logic            tmr_irq;
  logic            itcm_err;
  logic            armed;
  logic            stopped;
  logic            test_done;
  logic [31:0]     tohost_cnt;
  logic [15:0]     inj_cnt_ext;
  logic [15:0]     inj_cnt_sft;
  logic [15:0]     inj_cnt_tmr;

  modport master (
    output cmt_vld, cmt_pc, status_mie, itcm_rsp_read,
    input  ext_irq, sft_irq, tmr_irq, itcm_err, armed, stopped, test_done,
    input  tohost_cnt, inj_cnt_ext, inj_cnt_sft, inj_cnt_tmr
  );

  modport slave (
    input  cmt_vld, cmt_pc, status_mie, itcm_rsp_read,
    output ext_irq, sft_irq, tmr_irq, itcm_err, armed, stopped, test_done,
    output tohost_cnt, inj_cnt_ext, inj_cnt_sft, inj_cnt_tmr
  );
endinterface

// File: rtl/tb_irq_inject_sched_src_fsm.sv
// One interrupt source: waits a random gap, raises irq and holds it until the
// handler's pre-mret PC commits, then re-arms or retires once stopped.
module tb_irq_src_fsm
  import tb_irq_pkg::*;
#(
  parameter int DLY_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             armed,
  input  logic             stopped,
  input  logic             hit_ret,
  input  logic [DLY_W-1:0] dly_seed,
  output logic             irq,
  output logic [15:0]      inj_cnt
);

  src_state_t   state;
  logic [DLY_W:0] dly;
  logic [DLY_W:0] dly_load;

  // Gap of seed+1 cycles, so an all-zero slice still gives a 1-cycle gap
  assign dly_load = {1'b0, dly_seed} + (DLY_W+1)'(1);
  assign irq      = (state == SRC_ASSERT);

  // Injection state and completed-injection count; a stop abandons a pending gap
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= SRC_IDLE;
      inj_cnt <= '0;
    end else begin
      case (state)
        SRC_IDLE: if (armed) state <= SRC_WAIT;
        SRC_WAIT: begin
          if (stopped) state <= SRC_DONE;
          else if (dly == (DLY_W+1)'(1)) state <= SRC_ASSERT;
        end
        SRC_ASSERT: begin
          if (hit_ret) begin
            state <= stopped ? SRC_DONE : SRC_WAIT;
            if (inj_cnt != 16'hFFFF) inj_cnt <= inj_cnt + 16'd1;
          end
        end
        default: state <= SRC_DONE;
      endcase
    end
  end

  // Gap counter: reloaded while idle or holding so the exit edge captures a fresh slice
  always_ff @(posedge clk) begin
    if ((state == SRC_IDLE) || (state == SRC_ASSERT)) dly <= dly_load;
    else if (state == SRC_WAIT) dly <= dly - (DLY_W+1)'(1);
  end

endmodule

// File: rtl/tb_irq_inject_sched.sv
// Stimulus scheduler for the E203 interrupt / ITCM-error harness. Watches the
// commit PC, arms at PC_ARM, drives three IRQ sources with LFSR-random gaps and
// toggles an ITCM read-error window until enough tohost writes have been seen.
module tb_irq_inject_sched
  import tb_irq_pkg::*;
#(
  parameter int              PC_W       = PC_W_DEF,
  parameter logic [PC_W-1:0] PC_ARM     = PC_W'(PC_ARM_DEF),
  parameter logic [PC_W-1:0] PC_TOHOST  = PC_W'(PC_TOHOST_DEF),
  parameter logic [PC_W-1:0] PC_EXT_RET = PC_W'(PC_EXT_RET_DEF),
  parameter logic [PC_W-1:0] PC_SFT_RET = PC_W'(PC_SFT_RET_DEF),
  parameter logic [PC_W-1:0] PC_TMR_RET = PC_W'(PC_TMR_RET_DEF),
  parameter int              IRQ_DLY_W  = 10,
  parameter int              ERR_LO_W   = 5,
  parameter int              ERR_HI_W   = 8,
  parameter int unsigned     STOP_CNT   = 32,
  parameter int unsigned     DONE_CNT   = 8,
  parameter logic [15:0]     SEED       = 16'hACE1,
  parameter bit              ERR_EN     = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  tb_irq_inject_sched_if.slave bus
);

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam int ERR_CW = ((ERR_HI_W > ERR_LO_W) ? ERR_HI_W : ERR_LO_W) + 1;

  logic              hit_arm, hit_tohost, hit_ext, hit_sft, hit_tmr;
  logic [15:0]       lfsr;
  logic              armed, stopped, test_done, done_fired;
  logic [31:0]       tohost_cnt;
  err_state_t        err_state;
  logic [ERR_CW-1:0] err_len, err_lo_len, err_hi_len;

  assign hit_arm    = bus.cmt_vld && (bus.cmt_pc == PC_ARM);
  assign hit_tohost = bus.cmt_vld && (bus.cmt_pc == PC_TOHOST);
  assign hit_ext    = bus.cmt_vld && (bus.cmt_pc == PC_EXT_RET);
  assign hit_sft    = bus.cmt_vld && (bus.cmt_pc == PC_SFT_RET);
  assign hit_tmr    = bus.cmt_vld && (bus.cmt_pc == PC_TMR_RET);

  assign err_lo_len = ERR_CW'({1'b0, lfsr[ERR_LO_W-1:0]}) + ERR_CW'(1);
  assign err_hi_len = ERR_CW'({1'b0, lfsr[8 +: ERR_HI_W]}) + ERR_CW'(1);

  assign bus.armed      = armed;
  assign bus.stopped    = stopped;
  assign bus.test_done  = test_done;
  assign bus.tohost_cnt = tohost_cnt;
  // Error only gates live ITCM read responses while interrupts are enabled
  assign bus.itcm_err   = ERR_EN && (err_state == ERR_HI) && bus.status_mie && bus.itcm_rsp_read;

  // Arm flag, LFSR, saturating tohost count, stop flag and one-shot done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      armed      <= 1'b0;
      lfsr       <= SEED_EFF;
      tohost_cnt <= '0;
      stopped    <= 1'b0;
      test_done  <= 1'b0;
      done_fired <= 1'b0;
    end else begin
      if (hit_arm) armed <= 1'b1;
      if (armed) lfsr <= lfsr_step(lfsr);
      if (hit_tohost && (tohost_cnt != 32'hFFFF_FFFF)) tohost_cnt <= tohost_cnt + 32'd1;
      stopped   <= (tohost_cnt > 32'(STOP_CNT));
      test_done <= (tohost_cnt == 32'(DONE_CNT)) && !done_fired;
      if (tohost_cnt == 32'(DONE_CNT)) done_fired <= 1'b1;
    end
  end

  // Error window phases: LO/HI alternate; a stop lets the current phase run out
  always_ff @(posedge clk) begin
    if (rst) begin
      err_state <= ERR_IDLE;
    end else begin
      case (err_state)
        ERR_IDLE: if (armed) err_state <= ERR_LO;
        ERR_LO:   if (err_len == ERR_CW'(1)) err_state <= stopped ? ERR_DONE : ERR_HI;
        ERR_HI:   if (err_len == ERR_CW'(1)) err_state <= stopped ? ERR_DONE : ERR_LO;
        default:  err_state <= ERR_DONE;
      endcase
    end
  end

  // Phase length counter, loaded with the next phase length on each phase end
  always_ff @(posedge clk) begin
    case (err_state)
      ERR_IDLE: err_len <= err_lo_len;
      ERR_LO:   err_len <= (err_len == ERR_CW'(1)) ? err_hi_len : err_len - ERR_CW'(1);
      ERR_HI:   err_len <= (err_len == ERR_CW'(1)) ? err_lo_len : err_len - ERR_CW'(1);
      default:  err_len <= err_len;
    endcase
  end

  tb_irq_src_fsm #(.DLY_W(IRQ_DLY_W)) u_ext (
    .clk(clk), .rst(rst), .armed(armed), .stopped(stopped), .hit_ret(hit_ext),
    .dly_seed(lfsr[0 +: IRQ_DLY_W]), .irq(bus.ext_irq), .inj_cnt(bus.inj_cnt_ext)
  );

  tb_irq_src_fsm #(.DLY_W(IRQ_DLY_W)) u_sft (
    .clk(clk), .rst(rst), .armed(armed), .stopped(stopped), .hit_ret(hit_sft),
    .dly_seed(lfsr[3 +: IRQ_DLY_W]), .irq(bus.sft_irq), .inj_cnt(bus.inj_cnt_sft)
  );

  tb_irq_src_fsm #(.DLY_W(IRQ_DLY_W)) u_tmr (
    .clk(clk), .rst(rst), .armed(armed), .stopped(stopped), .hit_ret(hit_tmr),
    .dly_seed(lfsr[6 +: IRQ_DLY_W]), .irq(bus.tmr_irq), .inj_cnt(bus.inj_cnt_tmr)
  );

endmodule

// File: tb/tb_tb_irq_inject_sched.sv
// Bench for the IRQ / ITCM-error stimulus scheduler. Two instances share the
// same stimulus: dut_a (SEED=1, errors enabled) and dut_b (SEED=0, errors off).
module tb_tb_irq_inject_sched;

  localparam logic [31:0] PC_ARM     = 32'h8000_015C;
  localparam logic [31:0] PC_TOHOST  = 32'h8000_0086;
  localparam logic [31:0] PC_EXT_RET = 32'h8000_00A6;
  localparam logic [31:0] PC_SFT_RET = 32'h8000_00BE;
  localparam logic [31:0] PC_TMR_RET = 32'h8000_00D6;
  localparam logic [31:0] PC_OTHER   = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmt_vld = 1'b0;
  logic [31:0] cmt_pc = '0;
  logic        mie = 1'b0;
  logic        rd = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tb_irq_inject_sched_if #(.PC_W(32)) ifa ();
  tb_irq_inject_sched_if #(.PC_W(32)) ifb ();

  assign ifa.cmt_vld = cmt_vld;       assign ifb.cmt_vld = cmt_vld;
  assign ifa.cmt_pc = cmt_pc;         assign ifb.cmt_pc = cmt_pc;
  assign ifa.status_mie = mie;        assign ifb.status_mie = mie;
  assign ifa.itcm_rsp_read = rd;      assign ifb.itcm_rsp_read = rd;

  tb_irq_inject_sched #(.IRQ_DLY_W(2), .ERR_LO_W(6), .ERR_HI_W(8),
                        .SEED(16'h0001), .ERR_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa));
  tb_irq_inject_sched #(.IRQ_DLY_W(2), .ERR_LO_W(6), .ERR_HI_W(8),
                        .SEED(16'h0000), .ERR_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb));

  // ---------------- reference model (rules of the scheduler, cycle based) ----
  bit          m_armed, m_stopped, m_fired, m_done;
  int unsigned m_lfsr;
  longint      m_cnt;
  int          m_gap [3];   // remaining gap cycles, 0 = no gap running
  bit          m_hold[3];   // irq being held for the handler
  bit          m_fin [3];   // source retired
  int          m_inj [3];
  int          m_elo, m_ehi; // remaining cycles in the error-off / error-on phase
  bit          m_efin;

  function automatic int unsigned lfsr_next(int unsigned l);
    int unsigned fb;
    fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
    return ((l << 1) | fb) & 32'hFFFF;
  endfunction

  function automatic int gap_len(int i, int unsigned l);
    return int'((l >> (3 * i)) & 3) + 1;
  endfunction

  task automatic model_step();
    bit hr[3];
    bit h_arm, h_toh, stop_now;
    int lo_len, hi_len;
    if (rst) begin
      m_armed = 0; m_stopped = 0; m_fired = 0; m_done = 0; m_lfsr = 1; m_cnt = 0;
      for (int i = 0; i < 3; i++) begin
        m_gap[i] = 0; m_hold[i] = 0; m_fin[i] = 0; m_inj[i] = 0;
      end
      m_elo = 0; m_ehi = 0; m_efin = 0;
      return;
    end
    h_arm = cmt_vld && (cmt_pc == PC_ARM);
    h_toh = cmt_vld && (cmt_pc == PC_TOHOST);
    hr[0] = cmt_vld && (cmt_pc == PC_EXT_RET);
    hr[1] = cmt_vld && (cmt_pc == PC_SFT_RET);
    hr[2] = cmt_vld && (cmt_pc == PC_TMR_RET);
    stop_now = m_stopped;
    for (int i = 0; i < 3; i++) begin
      if (m_fin[i]) begin
      end else if (m_hold[i]) begin
        if (hr[i]) begin
          if (m_inj[i] < 65535) m_inj[i]++;
          m_hold[i] = 0;
          if (stop_now) m_fin[i] = 1;
          else m_gap[i] = gap_len(i, m_lfsr);
        end
      end else if (m_gap[i] > 0) begin
        if (stop_now) begin m_fin[i] = 1; m_gap[i] = 0; end
        else if (m_gap[i] == 1) begin m_gap[i] = 0; m_hold[i] = 1; end
        else m_gap[i]--;
      end else if (m_armed) begin
        m_gap[i] = gap_len(i, m_lfsr);
      end
    end
    lo_len = int'(m_lfsr & 63) + 1;
    hi_len = int'((m_lfsr >> 8) & 255) + 1;
    if (m_efin) begin
    end else if (m_elo > 0) begin
      if (m_elo == 1) begin m_elo = 0; if (stop_now) m_efin = 1; else m_ehi = hi_len; end
      else m_elo--;
    end else if (m_ehi > 0) begin
      if (m_ehi == 1) begin m_ehi = 0; if (stop_now) m_efin = 1; else m_elo = lo_len; end
      else m_ehi--;
    end else if (m_armed) begin
      m_elo = lo_len;
    end
    m_done = (m_cnt == 8) && !m_fired;
    if (m_cnt == 8) m_fired = 1;
    m_stopped = (m_cnt > 32);
    if (h_toh && (m_cnt < 64'h0000_0000_FFFF_FFFF)) m_cnt++;
    if (m_armed) m_lfsr = lfsr_next(m_lfsr);
    if (h_arm) m_armed = 1;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [86:0] ea, eb, aa, ab;
    logic        e_err;
    e_err = (m_ehi > 0) && mie && rd;
    ea = {m_armed, m_stopped, m_done, m_hold[0], m_hold[1], m_hold[2], e_err,
          32'(m_cnt), 16'(m_inj[0]), 16'(m_inj[1]), 16'(m_inj[2])};
    eb = ea;
    eb[80] = 1'b0;
    aa = {ifa.armed, ifa.stopped, ifa.test_done, ifa.ext_irq, ifa.sft_irq, ifa.tmr_irq,
          ifa.itcm_err, ifa.tohost_cnt, ifa.inj_cnt_ext, ifa.inj_cnt_sft, ifa.inj_cnt_tmr};
    ab = {ifb.armed, ifb.stopped, ifb.test_done, ifb.ext_irq, ifb.sft_irq, ifb.tmr_irq,
          ifb.itcm_err, ifb.tohost_cnt, ifb.inj_cnt_ext, ifb.inj_cnt_sft, ifb.inj_cnt_tmr};
    chk("model_a", aa, ea);
    chk("model_b", ab, eb);
  endtask

  // One clock: advance the model on the current inputs, then compare after the edge
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic commit(input logic v, input logic [31:0] pc);
    cmt_vld = v;
    cmt_pc  = pc;
    tick();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        vld;
    logic [31:0] pc;
    logic        armed, ext, sft, tmr;
    logic [15:0] inj_e, inj_s, inj_t;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited, pulses, irq_cycles;
    logic [31:0] cnt_at_pulse;

    // inputs -> expected outputs after that clock edge (SEED=1, 2-bit gaps)
    vecs[0]  = '{1'b0, PC_OTHER,   1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0};
    vecs[1]  = '{1'b1, PC_ARM,     1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0};
    vecs[2]  = '{1'b0, PC_OTHER,   1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0};
    vecs[3]  = '{1'b0, PC_OTHER,   1'b1, 1'b0, 1'b1, 1'b1, 16'd0, 16'd0, 16'd0};
    vecs[4]  = '{1'b0, PC_OTHER,   1'b1, 1'b1, 1'b1, 1'b1, 16'd0, 16'd0, 16'd0};
    vecs[5]  = '{1'b0, PC_EXT_RET, 1'b1, 1'b1, 1'b1, 1'b1, 16'd0, 16'd0, 16'd0};
    vecs[6]  = '{1'b1, PC_SFT_RET, 1'b1, 1'b1, 1'b0, 1'b1, 16'd0, 16'd1, 16'd0};
    vecs[7]  = '{1'b1, PC_EXT_RET, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1, 16'd1, 16'd0};
    vecs[8]  = '{1'b0, PC_OTHER,   1'b1, 1'b1, 1'b0, 1'b1, 16'd1, 16'd1, 16'd0};
    vecs[9]  = '{1'b0, PC_OTHER,   1'b1, 1'b1, 1'b1, 1'b1, 16'd1, 16'd1, 16'd0};
    vecs[10] = '{1'b1, PC_TMR_RET, 1'b1, 1'b1, 1'b1, 1'b0, 16'd1, 16'd1, 16'd1};
    vecs[11] = '{1'b0, PC_OTHER,   1'b1, 1'b1, 1'b1, 1'b1, 16'd1, 16'd1, 16'd1};

    // reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_a", {ifa.armed, ifa.stopped, ifa.test_done, ifa.ext_irq, ifa.sft_irq,
                    ifa.tmr_irq, ifa.itcm_err, ifa.tohost_cnt, ifa.inj_cnt_ext}, '0);
    rst = 1'b0;

    // table: arm, gap timing, hold until ret, ret with cmt_vld=0 ignored
    for (int i = 0; i < 12; i++) begin
      commit(vecs[i].vld, vecs[i].pc);
      chk($sformatf("vec%0d_a", i),
          {ifa.armed, ifa.ext_irq, ifa.sft_irq, ifa.tmr_irq,
           ifa.inj_cnt_ext, ifa.inj_cnt_sft, ifa.inj_cnt_tmr},
          {vecs[i].armed, vecs[i].ext, vecs[i].sft, vecs[i].tmr,
           vecs[i].inj_e, vecs[i].inj_s, vecs[i].inj_t});
      chk($sformatf("vec%0d_b", i),
          {ifb.armed, ifb.ext_irq, ifb.sft_irq, ifb.tmr_irq,
           ifb.inj_cnt_ext, ifb.inj_cnt_sft, ifb.inj_cnt_tmr},
          {vecs[i].armed, vecs[i].ext, vecs[i].sft, vecs[i].tmr,
           vecs[i].inj_e, vecs[i].inj_s, vecs[i].inj_t});
    end

    // reset while all irqs are held: irqs drop next cycle, no re-arm without PC_ARM
    rst = 1'b1;
    commit(1'b0, PC_OTHER);
    chk("rst_drop_irq", {ifa.ext_irq, ifa.sft_irq, ifa.tmr_irq, ifa.inj_cnt_ext}, '0);
    rst = 1'b0;
    repeat (20) commit(1'b1, PC_OTHER);
    chk("no_rearm", {ifa.armed, ifa.ext_irq, ifa.sft_irq, ifa.tmr_irq,
                     ifb.armed, ifb.ext_irq, ifb.sft_irq, ifb.tmr_irq}, '0);

    // randomized traffic against the model
    commit(1'b1, PC_ARM);
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = int'($urandom_range(0, 399));
      cmt_vld = ($urandom_range(0, 1) == 1);
      if (r < 2)        cmt_pc = PC_TOHOST;
      else if (r < 40)  cmt_pc = PC_EXT_RET;
      else if (r < 78)  cmt_pc = PC_SFT_RET;
      else if (r < 116) cmt_pc = PC_TMR_RET;
      else if (r < 124) cmt_pc = PC_ARM;
      else              cmt_pc = {16'h0000, 16'($urandom)};
      mie = ($urandom_range(0, 9) < 7);
      rd  = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 1499) == 0);
      tick();
    end
    rst = 1'b0;

    // fresh start for the error gate and tohost sequences
    rst = 1'b1;
    commit(1'b0, PC_OTHER);
    rst = 1'b0;
    commit(1'b1, PC_ARM);

    // error gate: wait for the HI phase, then drop each qualifier in turn
    mie = 1'b1; rd = 1'b1;
    waited = 0;
    while (!ifa.itcm_err && waited < 600) begin commit(1'b0, PC_OTHER); waited++; end
    chk("err_hi_seen", ifa.itcm_err, 1'b1);
    chk("err_en0", ifb.itcm_err, 1'b0);
    mie = 1'b0; #1;
    chk("err_mie0", ifa.itcm_err, 1'b0);
    mie = 1'b1; rd = 1'b0; #1;
    chk("err_rd0", ifa.itcm_err, 1'b0);
    rd = 1'b1; #1;
    chk("err_both1", ifa.itcm_err, 1'b1);

    // eight tohost commits: exactly one single-cycle test_done pulse at count 8
    pulses = 0;
    cnt_at_pulse = '0;
    for (int k = 0; k < 8; k++) begin
      commit(1'b1, PC_TOHOST);
      if (ifa.test_done) begin pulses++; cnt_at_pulse = ifa.tohost_cnt; end
    end
    chk("tohost_8", ifa.tohost_cnt, 32'd8);
    for (int k = 0; k < 20; k++) begin
      commit(1'b0, PC_OTHER);
      if (ifa.test_done) begin pulses++; cnt_at_pulse = ifa.tohost_cnt; end
    end
    chk("done_pulses", pulses, 1);
    chk("done_cnt", cnt_at_pulse, 32'd8);

    // stop while tmr is held, then its ret retires it for good
    waited = 0;
    while (!ifa.tmr_irq && waited < 100) begin commit(1'b0, PC_OTHER); waited++; end
    chk("tmr_held", ifa.tmr_irq, 1'b1);
    repeat (25) commit(1'b1, PC_TOHOST);
    commit(1'b0, PC_OTHER);
    commit(1'b0, PC_OTHER);
    chk("stopped", {ifa.stopped, ifa.tohost_cnt}, {1'b1, 32'd33});
    chk("tmr_still_held", ifa.tmr_irq, 1'b1);
    commit(1'b1, PC_TMR_RET);
    chk("tmr_released", ifa.tmr_irq, 1'b0);
    commit(1'b1, PC_EXT_RET);
    commit(1'b1, PC_SFT_RET);
    commit(1'b0, PC_OTHER);
    irq_cycles = 0;
    for (int c = 0; c < 5000; c++) begin
      int r;
      r = int'($urandom_range(0, 9));
      cmt_vld = 1'b1;
      case (r)
        0: cmt_pc = PC_EXT_RET;
        1: cmt_pc = PC_SFT_RET;
        2: cmt_pc = PC_TMR_RET;
        3: cmt_pc = PC_ARM;
        default: cmt_pc = {16'h0000, 16'($urandom)};
      endcase
      tick();
      if (ifa.ext_irq || ifa.sft_irq || ifa.tmr_irq) irq_cycles++;
    end
    chk("no_irq_after_stop", irq_cycles, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
